// File: rtl/ov7670_capture_ctrl_if.sv
// Pixel output port of the OV7670 capture sequencer: valid/ready pixel with its linear frame-buffer address.
interface ov7670_capture_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              pix_valid;
  logic              pix_ready;
  logic [15:0]       pix_data;
  logic [ADDR_W-1:0] pix_addr;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_addr,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_addr,
    output pix_ready
  );
endinterface

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame-capture sequencer: byte pairs -> RGB565 pixels with linear address, one-entry output register.
// Optional OV_CAP_LINE_ERR_EN adds O_ERR_CNT counting malformed lines (wrong length or odd byte count).
module ov7670_capture_ctrl #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                  I_CLK,
  input  logic                  I_RST,
  input  logic                  I_EN,
  input  logic                  I_VSYNC,
  input  logic                  I_HREF,
  input  logic                  I_PCLK,
  input  logic [7:0]            I_DATA,
  ov7670_capture_ctrl_if.master pix_if,
  output logic                  O_FRAME_DONE,
  output logic                  O_BUSY,
  output logic                  O_OVF
`ifdef OV_CAP_LINE_ERR_EN
  ,
  output logic [7:0]            O_ERR_CNT
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // One spare bit so an over-long line never wraps back into the active range.
  localparam int XW = $clog2(H_ACT + 2) + 1;
  localparam int YW = $clog2(V_ACT + 1);

  localparam logic [XW-1:0]     H_ACT_X  = XW'(H_ACT);
  localparam logic [XW-1:0]     X_MAX    = '1;
  localparam logic [YW-1:0]     V_ACT_Y  = YW'(V_ACT);
  localparam logic [YW-1:0]     V_LAST_Y = YW'(V_ACT - 1);
  localparam logic [ADDR_W-1:0] H_ACT_A  = ADDR_W'(H_ACT);

  logic [1:0]        state_q, state_d;
  logic              pclk_prev_q;
  logic              vs_prev_q;
  logic              href_prev_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              vld_q, vld_d;
  logic [15:0]       dat_q, dat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
`ifdef OV_CAP_LINE_ERR_EN
  logic [7:0]        err_q, err_d;
`endif

  logic pclk_rise;
  logic vs_fall;
  logic vs_rise;
  logic href_fall;
  logic active;
  logic frame_start;
  logic byte_stb;
  logic pix_form;
  logic in_range;
  logic pix_emit;
  logic line_end;
  logic accept;

  assign pclk_rise = I_PCLK & ~pclk_prev_q;
  assign vs_fall   = ~I_VSYNC & vs_prev_q;
  assign vs_rise   = I_VSYNC & ~vs_prev_q;
  assign href_fall = ~I_HREF & href_prev_q;

  assign active      = (state_q == ST_ACTIVE);
  assign frame_start = (state_q == ST_WAIT_VS) & I_EN & vs_fall;
  assign byte_stb    = active & pclk_rise & I_HREF;
  assign pix_form    = byte_stb & phase_q;
  assign in_range    = (x_q < H_ACT_X) && (y_q < V_ACT_Y);
  assign pix_emit    = pix_form & in_range;
  assign line_end    = active & href_fall;
  assign accept      = vld_q & pix_if.pix_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (I_EN) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (!I_EN)        state_d = ST_IDLE;
        else if (vs_fall) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (vs_rise) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = I_EN ? ST_WAIT_VS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line/byte position tracking; base_q holds y*H_ACT so addresses stay exact even on short lines.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    base_d  = base_q;
`ifdef OV_CAP_LINE_ERR_EN
    err_d   = err_q;
`endif
    if (frame_start) begin
      x_d     = '0;
      y_d     = '0;
      phase_d = 1'b0;
      base_d  = '0;
`ifdef OV_CAP_LINE_ERR_EN
      err_d   = '0;
`endif
    end else if (byte_stb) begin
      if (!phase_q) begin
        hi_d    = I_DATA;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        x_d     = (x_q == X_MAX) ? x_q : x_q + 1'b1;
      end
    end else if (line_end) begin
      phase_d = 1'b0;
      x_d     = '0;
      if (y_q < V_ACT_Y)  y_d    = y_q + 1'b1;
      if (y_q < V_LAST_Y) base_d = base_q + H_ACT_A;
`ifdef OV_CAP_LINE_ERR_EN
      if (((x_q != H_ACT_X) || phase_q) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
`endif
    end
  end

  // Single-entry output register: a stalled sink loses the new pixel, not the held one.
  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    addr_d = addr_q;
    ovf_d  = ovf_q;
    if (frame_start) ovf_d = 1'b0;
    if (accept)      vld_d = 1'b0;
    if (pix_emit) begin
      if (!vld_q || accept) begin
        vld_d  = 1'b1;
        dat_d  = {hi_q, I_DATA};
        addr_d = base_q + ADDR_W'(x_q);
      end else begin
        ovf_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q     <= ST_IDLE;
      pclk_prev_q <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      base_q      <= '0;
      vld_q       <= 1'b0;
      dat_q       <= '0;
      addr_q      <= '0;
      ovf_q       <= 1'b0;
`ifdef OV_CAP_LINE_ERR_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pclk_prev_q <= I_PCLK;
      vs_prev_q   <= I_VSYNC;
      href_prev_q <= I_HREF;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      base_q      <= base_d;
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      addr_q      <= addr_d;
      ovf_q       <= ovf_d;
`ifdef OV_CAP_LINE_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign pix_if.pix_valid = vld_q;
  assign pix_if.pix_data  = dat_q;
  assign pix_if.pix_addr  = addr_q;
  assign O_FRAME_DONE     = (state_q == ST_DONE);
  assign O_BUSY           = (state_q == ST_WAIT_VS) || (state_q == ST_ACTIVE);
  assign O_OVF            = ovf_q;
`ifdef OV_CAP_LINE_ERR_EN
  assign O_ERR_CNT        = err_q;
`endif

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed bench for ov7670_capture_ctrl on a 4x2 frame; accepted pixels are logged and checked per scenario.
module tb_ov7670_capture_ctrl;
  localparam int AW = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       vsync;
  logic       href;
  logic       pclk;
  logic [7:0] data;
  logic       frame_done;
  logic       busy;
  logic       ovf;
`ifdef OV_CAP_LINE_ERR_EN
  logic [7:0] err_cnt;
`endif

  ov7670_capture_ctrl_if #(.ADDR_W(AW)) pif ();

  ov7670_capture_ctrl #(.H_ACT(4), .V_ACT(2), .ADDR_W(AW)) dut (
    .I_CLK        (clk),
    .I_RST        (rst),
    .I_EN         (en),
    .I_VSYNC      (vsync),
    .I_HREF       (href),
    .I_PCLK       (pclk),
    .I_DATA       (data),
    .pix_if       (pif.master),
    .O_FRAME_DONE (frame_done),
    .O_BUSY       (busy),
    .O_OVF        (ovf)
`ifdef OV_CAP_LINE_ERR_EN
    ,
    .O_ERR_CNT    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [15:0]   cap_d[$];
  logic [AW-1:0] cap_a[$];

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (!rst && pif.pix_valid && pif.pix_ready) begin
      cap_d.push_back(pif.pix_data);
      cap_a.push_back(pif.pix_addr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    pclk = 1'b1;
    cyc(2);
    pclk = 1'b0;
    cyc(2);
  endtask

  task automatic send_line(input logic [7:0] first, input int npix);
    href = 1'b1;
    cyc(1);
    for (int i = 0; i < 2 * npix; i++) send_byte(8'(first + i));
    href = 1'b0;
    cyc(3);
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    cyc(4);
    vsync = 1'b0;
    cyc(4);
  endtask

  task automatic end_frame();
    vsync = 1'b1;
    cyc(6);
  endtask

  task automatic clear_log();
    cap_d.delete();
    cap_a.delete();
  endtask

  task automatic test_reset();
    logic [15:0] got_d;
    int d0;
    @(negedge clk);
    total += 4;
    if (pif.pix_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", pif.pix_valid); end
    if (pif.pix_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h want=0000", pif.pix_data); end
    if (busy !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%b%b want=00", busy, frame_done); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf); end
    @(posedge clk); #1;
    rst = 1'b0;
    // Start a frame, stall the sink so valid and overflow are set, then reset mid-frame.
    en = 1'b1;
    pif.pix_ready = 1'b0;
    cyc(2);
    start_frame();
    href = 1'b1;
    cyc(1);
    for (int i = 0; i < 4; i++) send_byte(8'(i));
    @(negedge clk);
    got_d = pif.pix_data;
    total += 2;
    if (pif.pix_valid !== 1'b1 || got_d !== 16'h0001) begin bad++; $display("FAIL pre_rst_pix got=%b/%h want=1/0001", pif.pix_valid, got_d); end
    if (ovf !== 1'b1) begin bad++; $display("FAIL pre_rst_ovf got=%b want=1", ovf); end
    @(posedge clk); #1;
    d0 = done_cnt;
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    total += 4;
    if (pif.pix_valid !== 1'b0 || pif.pix_addr !== 3'd0) begin bad++; $display("FAIL midrst_pix got=%b/%0d want=0/0", pif.pix_valid, pif.pix_addr); end
    if (pif.pix_data !== 16'h0) begin bad++; $display("FAIL midrst_data got=%h want=0000", pif.pix_data); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b want=0", ovf); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    href = 1'b0;
    cyc(2);
    end_frame();
    cyc(2);
    total += 2;
    if (done_cnt !== d0) begin bad++; $display("FAIL midrst_no_done got=%0d want=%0d", done_cnt, d0); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b want=0", busy); end
  endtask

  task automatic test_small_frame();
    logic [15:0] exp_d[8] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607,
                              16'h0809, 16'h0A0B, 16'h0C0D, 16'h0E0F};
    logic [15:0] got_d;
    logic [AW-1:0] got_a;
    int d0;
    en = 1'b1;
    pif.pix_ready = 1'b1;
    clear_log();
    d0 = done_cnt;
    cyc(2);
    start_frame();
    send_line(8'h00, 4);
    send_line(8'h08, 4);
    end_frame();
    total++;
    if (cap_d.size() !== 8) begin bad++; $display("FAIL t2_count got=%0d want=8", cap_d.size()); end
    for (int i = 0; i < 8; i++) begin
      got_d = (i < cap_d.size()) ? cap_d[i] : 16'hxxxx;
      got_a = (i < cap_a.size()) ? cap_a[i] : 3'bxxx;
      total += 2;
      if (got_d !== exp_d[i]) begin bad++; $display("FAIL t2_data[%0d] got=%h want=%h", i, got_d, exp_d[i]); end
      if (got_a !== 3'(i)) begin bad++; $display("FAIL t2_addr[%0d] got=%0d want=%0d", i, got_a, i); end
    end
    total += 3;
    if (done_cnt !== d0 + 1) begin bad++; $display("FAIL t2_done got=%0d want=%0d", done_cnt - d0, 1); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL t2_ovf got=%b want=0", ovf); end
    if (busy !== 1'b1) begin bad++; $display("FAIL t2_rearm_busy got=%b want=1", busy); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_d[6] = '{16'h1011, 16'h1617, 16'h1819, 16'h1A1B, 16'h1C1D, 16'h1E1F};
    logic [AW-1:0] exp_a[6] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [15:0] got_d;
    logic [AW-1:0] got_a;
    pif.pix_ready = 1'b0;
    clear_log();
    start_frame();
    href = 1'b1;
    cyc(1);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
    @(negedge clk);
    total += 2;
    if (pif.pix_valid !== 1'b1 || pif.pix_data !== 16'h1011 || pif.pix_addr !== 3'd0) begin
      bad++; $display("FAIL t3_held got=%b/%h/%0d want=1/1011/0", pif.pix_valid, pif.pix_data, pif.pix_addr);
    end
    if (ovf !== 1'b1) begin bad++; $display("FAIL t3_ovf_set got=%b want=1", ovf); end
    @(posedge clk); #1;
    pif.pix_ready = 1'b1;
    send_byte(8'h16);
    send_byte(8'h17);
    href = 1'b0;
    cyc(3);
    send_line(8'h18, 4);
    end_frame();
    total++;
    if (cap_d.size() !== 6) begin bad++; $display("FAIL t3_count got=%0d want=6", cap_d.size()); end
    for (int i = 0; i < 6; i++) begin
      got_d = (i < cap_d.size()) ? cap_d[i] : 16'hxxxx;
      got_a = (i < cap_a.size()) ? cap_a[i] : 3'bxxx;
      total += 2;
      if (got_d !== exp_d[i]) begin bad++; $display("FAIL t3_data[%0d] got=%h want=%h", i, got_d, exp_d[i]); end
      if (got_a !== exp_a[i]) begin bad++; $display("FAIL t3_addr[%0d] got=%0d want=%0d", i, got_a, exp_a[i]); end
    end
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL t3_ovf_sticky got=%b want=1", ovf); end
  endtask

  task automatic test_long_line();
    logic [15:0] exp_d[8] = '{16'h2021, 16'h2223, 16'h2425, 16'h2627,
                              16'h3031, 16'h3233, 16'h3435, 16'h3637};
    logic [15:0] got_d;
    logic [AW-1:0] got_a;
    pif.pix_ready = 1'b1;
    clear_log();
    start_frame();
    send_line(8'h20, 6);
    send_line(8'h30, 4);
    send_line(8'h40, 4);
    end_frame();
    total++;
    if (cap_d.size() !== 8) begin bad++; $display("FAIL t4_count got=%0d want=8", cap_d.size()); end
    for (int i = 0; i < 8; i++) begin
      got_d = (i < cap_d.size()) ? cap_d[i] : 16'hxxxx;
      got_a = (i < cap_a.size()) ? cap_a[i] : 3'bxxx;
      total += 2;
      if (got_d !== exp_d[i]) begin bad++; $display("FAIL t4_data[%0d] got=%h want=%h", i, got_d, exp_d[i]); end
      if (got_a !== 3'(i)) begin bad++; $display("FAIL t4_addr[%0d] got=%0d want=%0d", i, got_a, i); end
    end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL t4_ovf_cleared got=%b want=0", ovf); end
`ifdef OV_CAP_LINE_ERR_EN
    total++;
    if (err_cnt !== 8'd1) begin bad++; $display("FAIL t4_err_cnt got=%0d want=1", err_cnt); end
`endif
  endtask

  task automatic test_enable_drop();
    logic [15:0] got_d, want_d;
    logic [AW-1:0] got_a;
    int d0;
    pif.pix_ready = 1'b1;
    clear_log();
    d0 = done_cnt;
    start_frame();
    send_line(8'h50, 4);
    en = 1'b0;
    send_line(8'h58, 4);
    end_frame();
    total++;
    if (cap_d.size() !== 8) begin bad++; $display("FAIL t5_count got=%0d want=8", cap_d.size()); end
    for (int i = 0; i < 8; i++) begin
      got_d  = (i < cap_d.size()) ? cap_d[i] : 16'hxxxx;
      got_a  = (i < cap_a.size()) ? cap_a[i] : 3'bxxx;
      want_d = {8'(8'h50 + 2 * i), 8'(8'h51 + 2 * i)};
      total += 2;
      if (got_d !== want_d) begin bad++; $display("FAIL t5_data[%0d] got=%h want=%h", i, got_d, want_d); end
      if (got_a !== 3'(i)) begin bad++; $display("FAIL t5_addr[%0d] got=%0d want=%0d", i, got_a, i); end
    end
    total += 2;
    if (done_cnt !== d0 + 1) begin bad++; $display("FAIL t5_done got=%0d want=1", done_cnt - d0); end
    if (busy !== 1'b0) begin bad++; $display("FAIL t5_idle got=%b want=0", busy); end
    clear_log();
    start_frame();
    send_line(8'h60, 4);
    end_frame();
    total += 3;
    if (cap_d.size() !== 0) begin bad++; $display("FAIL t5_no_pix got=%0d want=0", cap_d.size()); end
    if (done_cnt !== d0 + 1) begin bad++; $display("FAIL t5_no_done got=%0d want=1", done_cnt - d0); end
    if (busy !== 1'b0) begin bad++; $display("FAIL t5_still_idle got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d[4] = '{16'h7071, 16'h7273, 16'h7475, 16'h7677};
    logic [15:0] got_d;
    logic [AW-1:0] got_a;
    en = 1'b1;
    pif.pix_ready = 1'b0;
    cyc(2);
    clear_log();
    start_frame();
    href = 1'b1;
    cyc(1);
    send_byte(8'h70);
    send_byte(8'h71);
    send_byte(8'h72);
    // Second pixel completes in the very cycle the held pixel is accepted.
    data = 8'h73;
    pclk = 1'b1;
    pif.pix_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total += 2;
    if (pif.pix_valid !== 1'b1 || pif.pix_data !== 16'h7273 || pif.pix_addr !== 3'd1) begin
      bad++; $display("FAIL t6_b2b got=%b/%h/%0d want=1/7273/1", pif.pix_valid, pif.pix_data, pif.pix_addr);
    end
    if (ovf !== 1'b0) begin bad++; $display("FAIL t6_ovf_mid got=%b want=0", ovf); end
    @(posedge clk); #1;
    pclk = 1'b0;
    cyc(2);
    for (int i = 4; i < 8; i++) send_byte(8'(8'h70 + i));
    href = 1'b0;
    cyc(3);
    end_frame();
    total++;
    if (cap_d.size() !== 4) begin bad++; $display("FAIL t6_count got=%0d want=4", cap_d.size()); end
    for (int i = 0; i < 4; i++) begin
      got_d = (i < cap_d.size()) ? cap_d[i] : 16'hxxxx;
      got_a = (i < cap_a.size()) ? cap_a[i] : 3'bxxx;
      total += 2;
      if (got_d !== exp_d[i]) begin bad++; $display("FAIL t6_data[%0d] got=%h want=%h", i, got_d, exp_d[i]); end
      if (got_a !== 3'(i)) begin bad++; $display("FAIL t6_addr[%0d] got=%0d want=%0d", i, got_a, i); end
    end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL t6_ovf_end got=%b want=0", ovf); end
  endtask

  initial begin
    rst           = 1'b1;
    en            = 1'b0;
    vsync         = 1'b0;
    href          = 1'b0;
    pclk          = 1'b0;
    data          = 8'h00;
    pif.pix_ready = 1'b0;
    test_reset();
    test_small_frame();
    test_overflow();
    test_long_line();
    test_enable_drop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
